// File: rtl/usb_tx_sender_pkg.sv
// Shared widths and FSM encodings for the USB TX bank sender.
package usb_tx_sender_pkg;

   localparam int USB_DATA_NBIT     = 16;
   localparam int USB_ADDR_NBIT     = 8;
   localparam int BUFFER_BADDR_NBIT = 2;

   typedef enum logic [1:0] {
      ST_TX_IDLE   = 2'd0,
      ST_TX_FETCH  = 2'd1,
      ST_TX_WRITE  = 2'd2,
      ST_TX_PKTEND = 2'd3
   } tx_state_t;

endpackage

// File: rtl/usb_tx_sender_if.sv
// Buffer-side and USB-FIFO-side signals of the TX sender.
interface usb_tx_sender_if
   import usb_tx_sender_pkg::*;
#(
   parameter int DATA_NBIT  = USB_DATA_NBIT,
   parameter int ADDR_NBIT  = USB_ADDR_NBIT,
   parameter int BADDR_NBIT = BUFFER_BADDR_NBIT
);

   logic                          buf_eop;
   logic [BADDR_NBIT-1:0]         buf_baddr;
   logic [BADDR_NBIT+ADDR_NBIT-1:0] buf_rd_addr;
   logic [DATA_NBIT-1:0]          buf_rd_data;
   logic                          usb_full_n;
   logic                          usb_wr;
   logic [DATA_NBIT-1:0]          usb_data;
   logic                          usb_pktend;
   logic                          busy;
   logic                          ovf;

   modport master (
      input  buf_eop, buf_baddr, buf_rd_data, usb_full_n,
      output buf_rd_addr, usb_wr, usb_data, usb_pktend,
      output busy, ovf
   );

   modport slave (
      output buf_eop, buf_baddr, buf_rd_data, usb_full_n,
      input  buf_rd_addr, usb_wr, usb_data, usb_pktend,
      input  busy, ovf
   );

endinterface

// File: rtl/usb_tx_sender_baddr_fifo.sv
// Two-entry queue of completed bank numbers (ping/pang).
module baddr_fifo #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         empty,
   output logic         full
);

   logic [W-1:0] slot [2];
   logic         rd_ptr;
   logic         wr_ptr;
   logic [1:0]   count;
   logic         do_push;
   logic         do_pop;

   // A pop frees the head slot, so a push into a full queue still fits.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            slot[wr_ptr] <= din;
            wr_ptr       <= ~wr_ptr;
         end
         if (do_pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end

   assign head  = slot[rd_ptr];
   assign empty = (count == 2'd0);
   assign full  = (count == 2'd2);

endmodule

// File: rtl/usb_tx_sender.sv
// Drains closed TX buffer banks, word by word, into the USB slave FIFO.
module usb_tx_sender
   import usb_tx_sender_pkg::*;
#(
   parameter int DATA_NBIT  = USB_DATA_NBIT,
   parameter int ADDR_NBIT  = USB_ADDR_NBIT,
   parameter int BADDR_NBIT = BUFFER_BADDR_NBIT
) (
   input logic             mclk,
   input logic             rst,
   usb_tx_sender_if.master bus
);

   tx_state_t             state;
   tx_state_t             state_nx;
   logic [BADDR_NBIT-1:0] bank;
   logic [ADDR_NBIT-1:0]  word_addr;
   logic [ADDR_NBIT-1:0]  cnt;
   logic [BADDR_NBIT-1:0] head;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  wr;
   logic                  pktend;
   logic                  last;
   logic                  busy_q;
   logic                  ovf_q;
   logic [DATA_NBIT-1:0]  word;

   baddr_fifo #(.W(BADDR_NBIT)) u_fifo (
      .clk   (mclk),
      .rst   (rst),
      .push  (bus.buf_eop),
      .pop   (pop),
      .din   (bus.buf_baddr),
      .head  (head),
      .empty (empty),
      .full  (full)
   );

   assign last = (cnt == {ADDR_NBIT{1'b1}});

   always_ff @(posedge mclk) begin
      if (rst) begin
         state <= ST_TX_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      wr       = 1'b0;
      pktend   = 1'b0;
      unique case (state)
         ST_TX_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               state_nx = ST_TX_FETCH;
            end
         end
         ST_TX_FETCH: begin
            state_nx = ST_TX_WRITE;
         end
         ST_TX_WRITE: begin
            wr = bus.usb_full_n;
            if (bus.usb_full_n) begin
               state_nx = last ? ST_TX_PKTEND : ST_TX_FETCH;
            end
         end
         ST_TX_PKTEND: begin
            pktend = bus.usb_full_n;
            if (bus.usb_full_n) begin
               state_nx = ST_TX_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge mclk) begin
      if (rst) begin
         bank      <= '0;
         word_addr <= '0;
         cnt       <= '0;
         busy_q    <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         if (pop) begin
            bank      <= head;
            word_addr <= '0;
            cnt       <= '0;
         end else if (wr && !last) begin
            word_addr <= word_addr + 1'b1;
            cnt       <= cnt + 1'b1;
         end
         // An incoming eop counts so busy rises the cycle after the push.
         busy_q <= (state != ST_TX_IDLE) || !empty || bus.buf_eop;
         ovf_q  <= ovf_q || (bus.buf_eop && full && !pop);
      end
   end

   assign word            = bus.buf_rd_data;
   assign bus.usb_data    = word;
   assign bus.buf_rd_addr = {bank, word_addr};
   assign bus.usb_wr      = wr;
   assign bus.usb_pktend  = pktend;
   assign bus.busy        = busy_q;
   assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_usb_tx_sender.sv
// Bench for usb_tx_sender: RAM model, write/pktend recorder, per-scenario tasks.
module tb_usb_tx_sender;

   import usb_tx_sender_pkg::*;

   localparam int NW = 256;

   typedef struct {
      int          cyc;
      logic [9:0]  addr;
      logic [15:0] data;
   } wr_t;

   logic mclk = 1'b0;
   logic rst  = 1'b1;

   always #5 mclk = ~mclk;

   usb_tx_sender_if #(.DATA_NBIT(16), .ADDR_NBIT(8), .BADDR_NBIT(2)) bus ();

   usb_tx_sender #(.DATA_NBIT(16), .ADDR_NBIT(8), .BADDR_NBIT(2)) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   int cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   logic [15:0] mem [1024];
   always @(posedge mclk) bus.buf_rd_data <= mem[bus.buf_rd_addr];

   wr_t wr_q [$];
   int  pk_q [$];
   wr_t exp_q [$];

   always @(negedge mclk) begin
      wr_t w;
      if (bus.usb_wr === 1'b1) begin
         w.cyc  = cyc;
         w.addr = bus.buf_rd_addr;
         w.data = bus.usb_data;
         wr_q.push_back(w);
      end
      if (bus.usb_pktend === 1'b1) pk_q.push_back(cyc);
   end

   int vectors = 0;
   int miscompares = 0;
   int t0;

   // Expected content of one full bank, ascending word order.
   function automatic void add_bank(input logic [1:0] b);
      for (int i = 0; i < NW; i++) begin
         wr_t e;
         e.cyc  = -1;
         e.addr = {b, 8'(i)};
         e.data = mem[{b, 8'(i)}];
         exp_q.push_back(e);
      end
   endfunction

   task automatic step();
      @(posedge mclk);
      #1;
   endtask

   task automatic clear_logs();
      exp_q.delete();
      wr_q.delete();
      pk_q.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic start_bank(input logic [1:0] b);
      step();
      t0 = cyc;
      bus.buf_eop   = 1'b1;
      bus.buf_baddr = b;
   endtask

   task automatic test_reset();
      bus.buf_eop    = 1'b0;
      bus.buf_baddr  = '0;
      bus.usb_full_n = 1'b1;
      rst = 1'b1;
      step();
      step();
      @(negedge mclk);
      vectors += 5;
      if (bus.usb_wr !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_wr: got %b want 0", bus.usb_wr);
      end
      if (bus.usb_pktend !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_pktend: got %b want 0", bus.usb_pktend);
      end
      if (bus.buf_rd_addr !== 10'h000) begin
         miscompares++;
         $display("FAIL reset_addr: got %h want 000", bus.buf_rd_addr);
      end
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
      if (bus.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_ovf: got %b want 0", bus.ovf);
      end
      rst = 1'b0;
   endtask

   task automatic test_single();
      logic b1, b515, b516;
      for (int i = 0; i < NW; i++) mem[10'h100 + i] = 16'h1000 + 16'(i);
      clear_logs();
      add_bank(2'd1);
      start_bank(2'd1);
      for (int r = 1; r <= 530; r++) begin
         step();
         bus.buf_eop = 1'b0;
         @(negedge mclk);
         if (r == 1) b1 = bus.busy;
         if (r == 515) b515 = bus.busy;
         if (r == 516) b516 = bus.busy;
      end
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL single_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            miscompares++;
            $display("FAIL single_word %0d: got %h/%h want %h/%h", i,
                     wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors += 3;
      if (wr_q.size() == NW) begin
         if (wr_q[0].cyc - t0 != 3) begin
            miscompares++;
            $display("FAIL single_first_cyc: got %0d want 3", wr_q[0].cyc - t0);
         end
         if (wr_q[NW-1].cyc - t0 != 513) begin
            miscompares++;
            $display("FAIL single_last_cyc: got %0d want 513", wr_q[NW-1].cyc - t0);
         end
      end else miscompares += 2;
      if (pk_q.size() != 1 || pk_q[0] - t0 != 514) begin
         miscompares++;
         $display("FAIL single_pktend: got %0d strobes want 1 at 514", pk_q.size());
      end
      vectors += 3;
      if (b1 !== 1'b1) begin
         miscompares++;
         $display("FAIL single_busy_rise: got %b want 1", b1);
      end
      if (b515 !== 1'b1) begin
         miscompares++;
         $display("FAIL single_busy_515: got %b want 1", b515);
      end
      if (b516 !== 1'b0) begin
         miscompares++;
         $display("FAIL single_busy_fall: got %b want 0", b516);
      end
   endtask

   task automatic test_stall();
      clear_logs();
      add_bank(2'd0);
      start_bank(2'd0);
      for (int r = 1; r <= 545; r++) begin
         step();
         bus.buf_eop    = 1'b0;
         bus.usb_full_n = !((r >= 17 && r < 22) || (r >= 519 && r < 522));
      end
      bus.usb_full_n = 1'b1;
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL stall_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            miscompares++;
            $display("FAIL stall_word %0d: got %h/%h want %h/%h", i,
                     wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors += 2;
      if (wr_q.size() < 8 || wr_q[7].cyc - t0 != 22) begin
         miscompares++;
         $display("FAIL stall_word7_cyc: got %0d want 22",
                  wr_q.size() < 8 ? -1 : wr_q[7].cyc - t0);
      end
      if (pk_q.size() != 1 || pk_q[0] - t0 != 522) begin
         miscompares++;
         $display("FAIL stall_pktend: got %0d strobes want 1 at 522", pk_q.size());
      end
   endtask

   task automatic test_random_stall();
      bit   fn [1300];
      int   t;
      int   pk;
      logic [1:0] b;
      for (int i = 0; i < 1300; i++) fn[i] = 1'b1;
      b = 2'($urandom_range(3));
      clear_logs();
      add_bank(b);
      start_bank(b);
      for (int r = 1; r < 1300; r++) begin
         step();
         bus.buf_eop = 1'b0;
         if (r < 900) fn[r] = ($urandom_range(3) != 0);
         bus.usb_full_n = fn[r];
      end
      // Each word needs one fetch cycle plus one non-full write cycle.
      t = 3;
      for (int i = 0; i < NW; i++) begin
         while (t < 1299 && !fn[t]) t++;
         exp_q[i].cyc = t0 + t;
         t += (i == NW - 1) ? 1 : 2;
      end
      while (t < 1299 && !fn[t]) t++;
      pk = t0 + t;
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL rand_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data ||
             wr_q[i].cyc != exp_q[i].cyc) begin
            miscompares++;
            $display("FAIL rand_word %0d: got %h/%h@%0d want %h/%h@%0d", i,
                     wr_q[i].addr, wr_q[i].data, wr_q[i].cyc,
                     exp_q[i].addr, exp_q[i].data, exp_q[i].cyc);
         end
      end
      vectors++;
      if (pk_q.size() != 1 || pk_q[0] != pk) begin
         miscompares++;
         $display("FAIL rand_pktend: got %0d strobes want 1 at %0d", pk_q.size(), pk);
      end
   endtask

   task automatic test_back_to_back();
      int   low_cnt;
      logic b1030;
      low_cnt = 0;
      clear_logs();
      add_bank(2'd2);
      add_bank(2'd3);
      start_bank(2'd2);
      for (int r = 1; r <= 1040; r++) begin
         step();
         bus.buf_eop = (r == 10);
         bus.buf_baddr = 2'd3;
         @(negedge mclk);
         if (r <= 1029 && bus.busy !== 1'b1) low_cnt++;
         if (r == 1030) b1030 = bus.busy;
      end
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL b2b_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            miscompares++;
            $display("FAIL b2b_word %0d: got %h/%h want %h/%h", i,
                     wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors += 4;
      if (wr_q.size() <= NW || wr_q[NW].cyc - t0 != 517) begin
         miscompares++;
         $display("FAIL b2b_second_start: got %0d want 517",
                  wr_q.size() <= NW ? -1 : wr_q[NW].cyc - t0);
      end
      if (pk_q.size() != 2 || pk_q[1] - t0 != 1028) begin
         miscompares++;
         $display("FAIL b2b_pktend: got %0d strobes want 2, last at 1028", pk_q.size());
      end
      if (low_cnt != 0) begin
         miscompares++;
         $display("FAIL b2b_busy_gap: got %0d idle cycles want 0", low_cnt);
      end
      if (b1030 !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_busy_fall: got %b want 0", b1030);
      end
   endtask

   task automatic test_overflow();
      logic o9, o11;
      do_reset();
      clear_logs();
      add_bank(2'd0);
      add_bank(2'd1);
      add_bank(2'd2);
      start_bank(2'd0);
      for (int r = 1; r <= 1560; r++) begin
         step();
         bus.buf_eop   = (r == 5 || r == 7 || r == 9);
         bus.buf_baddr = 2'((r - 3) / 2);
         @(negedge mclk);
         if (r == 9) o9 = bus.ovf;
         if (r == 11) o11 = bus.ovf;
      end
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL ovf_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            miscompares++;
            $display("FAIL ovf_word %0d: got %h/%h want %h/%h", i,
                     wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors += 4;
      if (o9 !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_before_drop: got %b want 0", o9);
      end
      if (o11 !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_after_drop: got %b want 1", o11);
      end
      if (bus.ovf !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: got %b want 1", bus.ovf);
      end
      if (pk_q.size() != 3) begin
         miscompares++;
         $display("FAIL ovf_banks: got %0d pktends want 3", pk_q.size());
      end
   endtask

   task automatic test_push_pop();
      logic o516;
      do_reset();
      clear_logs();
      for (int b = 0; b < 4; b++) add_bank(2'(b));
      start_bank(2'd0);
      for (int r = 1; r <= 2080; r++) begin
         step();
         bus.buf_eop = (r == 4 || r == 6 || r == 515);
         bus.buf_baddr = (r == 4) ? 2'd1 : (r == 6) ? 2'd2 : 2'd3;
         @(negedge mclk);
         if (r == 516) o516 = bus.ovf;
      end
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL pp_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            miscompares++;
            $display("FAIL pp_word %0d: got %h/%h want %h/%h", i,
                     wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors += 3;
      if (o516 !== 1'b0) begin
         miscompares++;
         $display("FAIL pp_ovf_516: got %b want 0", o516);
      end
      if (bus.ovf !== 1'b0) begin
         miscompares++;
         $display("FAIL pp_ovf_end: got %b want 0", bus.ovf);
      end
      if (pk_q.size() != 4) begin
         miscompares++;
         $display("FAIL pp_banks: got %0d pktends want 4", pk_q.size());
      end
   endtask

   task automatic test_reset_mid();
      logic       w204, p204, b204;
      logic [9:0] a204;
      do_reset();
      clear_logs();
      add_bank(2'd1);
      while (exp_q.size() > 101) void'(exp_q.pop_back());
      start_bank(2'd1);
      for (int r = 1; r <= 230; r++) begin
         step();
         bus.buf_eop = 1'b0;
         rst = (r == 203);
         @(negedge mclk);
         if (r == 204) begin
            w204 = bus.usb_wr;
            p204 = bus.usb_pktend;
            b204 = bus.busy;
            a204 = bus.buf_rd_addr;
         end
      end
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL rmid_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            miscompares++;
            $display("FAIL rmid_word %0d: got %h/%h want %h/%h", i,
                     wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors += 5;
      if (w204 !== 1'b0 || p204 !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_strobes: got wr=%b pktend=%b want 0 0", w204, p204);
      end
      if (b204 !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_busy: got %b want 0", b204);
      end
      if (a204 !== 10'h000) begin
         miscompares++;
         $display("FAIL rmid_addr: got %h want 000", a204);
      end
      if (pk_q.size() != 0) begin
         miscompares++;
         $display("FAIL rmid_pktend: got %0d strobes want 0", pk_q.size());
      end
      if (bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL rmid_queue_empty: got busy %b want 0", bus.busy);
      end
      clear_logs();
      add_bank(2'd2);
      start_bank(2'd2);
      for (int r = 1; r <= 530; r++) begin
         step();
         bus.buf_eop = 1'b0;
      end
      vectors++;
      if (wr_q.size() != exp_q.size()) begin
         miscompares++;
         $display("FAIL restart_count: got %0d want %0d", wr_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
         vectors++;
         if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
            miscompares++;
            $display("FAIL restart_word %0d: got %h/%h want %h/%h", i,
                     wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
         end
      end
      vectors += 2;
      if (wr_q.size() == 0 || wr_q[0].cyc - t0 != 3) begin
         miscompares++;
         $display("FAIL restart_first_cyc: got %0d want 3",
                  wr_q.size() == 0 ? -1 : wr_q[0].cyc - t0);
      end
      if (pk_q.size() != 1 || pk_q[0] - t0 != 514) begin
         miscompares++;
         $display("FAIL restart_pktend: got %0d strobes want 1 at 514", pk_q.size());
      end
   endtask

   initial begin
      bus.buf_eop    = 1'b0;
      bus.buf_baddr  = '0;
      bus.usb_full_n = 1'b1;
      for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
      test_reset();
      test_single();
      test_stall();
      test_random_stall();
      test_back_to_back();
      test_overflow();
      test_push_pop();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
